four_bit_full_adder_non_ripple: RTL and testbench
=================================================

# four_bit_full_adder_non_ripple

Combinational 4-bit binary adder with carry-in and carry-out. All carries come from carry-lookahead (generate/propagate) equations, not a ripple chain. Serves as the leaf adder slice in datapath arithmetic and exports group propagate/generate so slices can be cascaded under a higher-level lookahead unit. A registered copy of the result is provided for pipelined users. The combinational result path does not depend on the clock.

## Interface
Parameters:
- none; width is fixed at 4 bits.

Ports:
- clk, input, 1: clock; used only by the registered outputs.
- rst, input, 1: reset, asynchronous, active-high; clears the registered outputs.
- a, input, 4: addend A, unsigned.
- b, input, 4: addend B, unsigned.
- cin, input, 1: carry-in.
- sum, output, 4: combinational sum bits, (a + b + cin) mod 16.
- cout, output, 1: combinational carry-out, bit 4 of a + b + cin.
- group_p, output, 1: group propagate, equal to &(a ^ b).
- group_g, output, 1: group generate; high when the slice produces a carry independent of cin.
- sum_q, output, 4: sum registered on clk.
- cout_q, output, 1: cout registered on clk.

## Operation
- Per-bit terms:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
- Carries are written as flattened sum-of-products. No carry expression may reference another computed carry.
  - c0 = cin
  - c1 = g0 | p0·cin
  - c2 = g1 | p1·g0 | p1·p0·cin
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·cin
  - c4 = group_g | group_p·cin
- Group terms:
  - group_g = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - group_p = p3·p2·p1·p0
- Outputs: sum[i] = p[i] ^ c[i]; cout = c4.
- Arithmetic rule: {cout, sum} must equal a + b + cin as a 5-bit unsigned value, for all 512 input combinations. The maximum result is 31.
- No X-propagation masking and no saturation; wrap-around happens purely via cout.
- Registered path: on the rising edge of clk, sum_q <= sum and cout_q <= cout.

## Timing
- sum, cout, group_p and group_g are purely combinational.
  - They settle within one propagation delay of any change on a, b or cin.
  - They are unaffected by clk and rst.
- Combinational carry depth is constant: two logic levels after p/g generation, the same for every bit.
- sum_q and cout_q have 1-cycle latency: inputs present before edge N appear after edge N.
- Reset:
  - rst high forces sum_q = 4'b0000 and cout_q = 0 immediately, without waiting for a clock edge.
  - The registers stay cleared while rst is high.
  - The first capture happens at the first rising edge after rst deasserts.
- Reset mid-operation clears only the registered outputs. The combinational outputs keep tracking the inputs.

## Structure
- Shared package: localparam ADD_W = 4. No typedefs are required.
- One natural sub-module: cla_pg_unit.
  - Computes p[3:0] and g[3:0], the carries c1..c4, group_p and group_g.
  - Top level instantiates it, forms sum = p ^ {c3, c2, c1, cin}, and holds the output register.
- No behavioural "+" operator in RTL. The lookahead equations are the implementation; "+" is allowed only in the bench model.

## Test plan
- a=0, b=0, cin=0 -> sum=0000, cout=0, group_p=0, group_g=0.
- a=15, b=15, cin=1 -> sum=1111, cout=1 (total 31), group_g=1.
- a=15, b=0, cin=1 -> sum=0000, cout=1, group_p=1, group_g=0. This is the full-propagate carry path.
- a=5, b=10, cin=0 -> sum=1111, cout=0, group_p=1; then cin=1 -> sum=0000, cout=1.
- Exhaustive sweep of a 0..15, b 0..15, cin 0..1, 5 ns settle each step -> {cout, sum} == a + b + cin for all 512 combinations.
- Registered path:
  - Apply a=9, b=8, cin=1 and clock -> sum_q=0010, cout_q=1 after one edge.
  - Assert rst between edges -> sum_q=0000 and cout_q=0 immediately, while sum and cout stay 0010 and 1.

Source files
------------

// File: rtl/four_bit_full_adder_non_ripple_pkg.sv
// Shared constants for the 4-bit carry-lookahead adder slice.
package four_bit_full_adder_non_ripple_pkg;

  localparam int unsigned ADD_W = 4;

endpackage

// File: rtl/cla_pg_unit.sv
// Propagate/generate and flattened lookahead carries for one 4-bit slice.
module cla_pg_unit
  import four_bit_full_adder_non_ripple_pkg::*;
(
  input  logic [ADD_W-1:0] a_i,
  input  logic [ADD_W-1:0] b_i,
  input  logic             cin_i,
  output logic [ADD_W-1:0] p_o,
  output logic [ADD_W-1:0] carry_o,   // {c4, c3, c2, c1}
  output logic             group_p_o,
  output logic             group_g_o
);

  logic [ADD_W-1:0] g;
  logic [ADD_W-1:0] p;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is a two-level sum of products over p/g/cin; none feeds another.
  assign group_g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign group_p_o = p[3] & p[2] & p[1] & p[0];

  assign carry_o[0] = g[0] | (p[0] & cin_i);
  assign carry_o[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign carry_o[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
  assign carry_o[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & cin_i);

  assign p_o = p;

endmodule

// File: rtl/four_bit_full_adder_non_ripple.sv
// 4-bit lookahead adder slice with group P/G export and a registered result copy.
module four_bit_full_adder_non_ripple
  import four_bit_full_adder_non_ripple_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] sum,
  output logic             cout,
  output logic             group_p,
  output logic             group_g,
  output logic [ADD_W-1:0] sum_q,
  output logic             cout_q
);

  logic [ADD_W-1:0] p;
  logic [ADD_W-1:0] carry;
  logic [ADD_W-1:0] sum_d;
  logic             cout_d;

  cla_pg_unit u_cla_pg_unit (
    .a_i       (a),
    .b_i       (b),
    .cin_i     (cin),
    .p_o       (p),
    .carry_o   (carry),
    .group_p_o (group_p),
    .group_g_o (group_g)
  );

  always_comb begin
    sum_d  = p ^ {carry[2:0], cin};
    cout_d = carry[3];
  end

  assign sum  = sum_d;
  assign cout = cout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

endmodule

// File: tb/tb_four_bit_full_adder_non_ripple.sv
// Directed-vector, exhaustive and registered-path checks for the 4-bit lookahead adder.
module tb_four_bit_full_adder_non_ripple;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       group_p;
  logic       group_g;
  logic [3:0] sum_q;
  logic       cout_q;

  int checks;
  int errors;

  four_bit_full_adder_non_ripple dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .sum     (sum),
    .cout    (cout),
    .group_p (group_p),
    .group_g (group_g),
    .sum_q   (sum_q),
    .cout_q  (cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       gp;
    logic       gg;
  } vec_t;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  initial begin
    vec_t vecs [8];
    logic [4:0] total;
    logic       exp_gg;

    checks = 0;
    errors = 0;

    vecs[0] = '{a: 4'd0,  b: 4'd0,  cin: 1'b0, sum: 4'b0000, cout: 1'b0, gp: 1'b0, gg: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd15, cin: 1'b1, sum: 4'b1111, cout: 1'b1, gp: 1'b0, gg: 1'b1};
    vecs[2] = '{a: 4'd15, b: 4'd0,  cin: 1'b1, sum: 4'b0000, cout: 1'b1, gp: 1'b1, gg: 1'b0};
    vecs[3] = '{a: 4'd5,  b: 4'd10, cin: 1'b0, sum: 4'b1111, cout: 1'b0, gp: 1'b1, gg: 1'b0};
    vecs[4] = '{a: 4'd5,  b: 4'd10, cin: 1'b1, sum: 4'b0000, cout: 1'b1, gp: 1'b1, gg: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd8,  cin: 1'b1, sum: 4'b0010, cout: 1'b1, gp: 1'b0, gg: 1'b1};
    vecs[6] = '{a: 4'd7,  b: 4'd1,  cin: 1'b0, sum: 4'b1000, cout: 1'b0, gp: 1'b0, gg: 1'b0};
    vecs[7] = '{a: 4'd8,  b: 4'd8,  cin: 1'b0, sum: 4'b0000, cout: 1'b1, gp: 1'b0, gg: 1'b1};

    // Reset state: registers cleared asynchronously before any edge.
    rst = 1'b1;
    a   = 4'd3;
    b   = 4'd4;
    cin = 1'b0;
    #2;
    check("reset_sum_q", {1'b0, sum_q}, 5'd0);
    check("reset_cout_q", {4'd0, cout_q}, 5'd0);
    check("reset_comb_sum", {cout, sum}, 5'd7);

    for (int i = 0; i < 8; i++) begin
      a   = vecs[i].a;
      b   = vecs[i].b;
      cin = vecs[i].cin;
      #5;
      check($sformatf("vec%0d_sum", i), {1'b0, sum}, {1'b0, vecs[i].sum});
      check($sformatf("vec%0d_cout", i), {4'd0, cout}, {4'd0, vecs[i].cout});
      check($sformatf("vec%0d_group_p", i), {4'd0, group_p}, {4'd0, vecs[i].gp});
      check($sformatf("vec%0d_group_g", i), {4'd0, group_g}, {4'd0, vecs[i].gg});
    end

    // Exhaustive sweep against an arithmetic model.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a   = 4'(ia);
          b   = 4'(ib);
          cin = 1'(ic);
          #5;
          total  = 5'(ia + ib + ic);
          exp_gg = (ia + ib) > 15;
          check($sformatf("sweep_%0d_%0d_%0d", ia, ib, ic), {cout, sum}, total);
          check($sformatf("sweep_gp_%0d_%0d", ia, ib), {4'd0, group_p}, {4'd0, &(4'(ia) ^ 4'(ib))});
          check($sformatf("sweep_gg_%0d_%0d", ia, ib), {4'd0, group_g}, {4'd0, exp_gg});
        end
      end
    end

    // Registered path: release reset on a falling edge, then capture 9+8+1.
    @(negedge clk);
    rst = 1'b0;
    a   = 4'd9;
    b   = 4'd8;
    cin = 1'b1;
    #1;
    check("pre_edge_sum_q", {cout_q, sum_q}, 5'd0);
    @(posedge clk);
    #1;
    check("reg_sum_q", {1'b0, sum_q}, 5'b00010);
    check("reg_cout_q", {4'd0, cout_q}, 5'd1);

    // Async reset between edges clears only the registers.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_sum_q", {1'b0, sum_q}, 5'd0);
    check("midrst_cout_q", {4'd0, cout_q}, 5'd0);
    check("midrst_sum", {1'b0, sum}, 5'b00010);
    check("midrst_cout", {4'd0, cout}, 5'd1);

    // Held reset survives an edge.
    @(posedge clk);
    #1;
    check("held_rst_q", {cout_q, sum_q}, 5'd0);

    // First capture after deassert, with new inputs.
    @(negedge clk);
    rst = 1'b0;
    a   = 4'd6;
    b   = 4'd7;
    cin = 1'b0;
    #1;
    check("post_rst_pre_edge", {cout_q, sum_q}, 5'd0);
    @(posedge clk);
    #1;
    check("post_rst_capture", {cout_q, sum_q}, 5'd13);

    // Latency: input change after an edge does not appear until the next one.
    a   = 4'd15;
    b   = 4'd15;
    cin = 1'b1;
    #2;
    check("latency_hold", {cout_q, sum_q}, 5'd13);
    @(posedge clk);
    #1;
    check("latency_update", {cout_q, sum_q}, 5'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
